// File: rtl/scroll_displayer_pkg.sv
// Shared mode encodings, blink phases and active-low {g,f,e,d,c,b,a} segment
// codes for the message scroller.
package scroll_pkg;

  typedef logic [1:0] mode_t;
  typedef logic [6:0] seg_t;

  localparam mode_t MODE_SCROLL_L = 2'd0;
  localparam mode_t MODE_SCROLL_R = 2'd1;
  localparam mode_t MODE_STATIC   = 2'd2;
  localparam mode_t MODE_BLINK    = 2'd3;

  localparam logic PHASE_SHOWN  = 1'b0;
  localparam logic PHASE_HIDDEN = 1'b1;

  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_DASH  = 7'h3F;
  localparam seg_t SEG_0     = 7'h40;
  localparam seg_t SEG_1     = 7'h79;
  localparam seg_t SEG_2     = 7'h24;
  localparam seg_t SEG_3     = 7'h30;
  localparam seg_t SEG_4     = 7'h19;
  localparam seg_t SEG_5     = 7'h12;
  localparam seg_t SEG_6     = 7'h02;
  localparam seg_t SEG_7     = 7'h78;
  localparam seg_t SEG_8     = 7'h00;
  localparam seg_t SEG_9     = 7'h10;
  localparam seg_t SEG_A     = 7'h08;
  localparam seg_t SEG_B     = 7'h00;
  localparam seg_t SEG_U     = 7'h41;

endpackage

// File: rtl/scroll_displayer_tick.sv
// One-cycle step enable every DIV cycles of clk; the count only advances
// while en is high, so a pause resumes from the held value.
module tick_gen #(
  parameter int DIV = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/scroll_displayer.sv
// Multi-digit 7-segment message scroller with LED bar: a writable segment
// buffer stepped across the digits in scroll-left/right, static or blink mode.
module scroll_displayer
  import scroll_pkg::*;
#(
  parameter  int NUM_DIGITS = 8,
  parameter  int MSG_DEPTH  = 16,
  parameter  int LED_W      = 8,
  parameter  int TICK_DIV   = 2_000_000,
  localparam int ADDR_W     = $clog2(MSG_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [6:0]              wr_data,
  input  logic                    cfg_we,
  input  logic [1:0]              cfg_mode,
  input  logic [ADDR_W:0]         cfg_len,
  output logic [7*NUM_DIGITS-1:0] digits,
  output logic [LED_W-1:0]        led,
  output logic                    frame_done
);

  localparam int              DW      = 7 * NUM_DIGITS;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(MSG_DEPTH);

  seg_t              msg [MSG_DEPTH];
  mode_t             mode;
  logic [ADDR_W:0]   len;
  logic [ADDR_W-1:0] rd_ptr;
  logic              phase;
  logic              tick;

  logic [ADDR_W:0]   len_clamped;
  logic [ADDR_W-1:0] cfg_start;
  logic [ADDR_W-1:0] last_idx;
  logic              wr_ok;
  seg_t              rd_seg;
  logic [DW-1:0]     static_win;

  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  // NOTE: every always_comb output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    len_clamped = cfg_len;
    if (cfg_len == '0) begin
      len_clamped = (ADDR_W + 1)'(1);
    end else if (cfg_len > DEPTH_L) begin
      len_clamped = DEPTH_L;
    end
  end

  assign cfg_start = (mode_t'(cfg_mode) == MODE_SCROLL_R) ? ADDR_W'(len_clamped - 1'b1) : '0;
  assign last_idx  = ADDR_W'(len - 1'b1);
  assign wr_ok     = wr_en && ({1'b0, wr_addr} < DEPTH_L);
  assign rd_seg    = msg[rd_ptr];

  // Fixed window of the first NUM_DIGITS entries, blank past the message end.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_win
    if (g < MSG_DEPTH) begin : g_in
      assign static_win[DW-1-7*g -: 7] = ((ADDR_W + 1)'(g) < len) ? msg[ADDR_W'(g)] : SEG_BLANK;
    end else begin : g_out
      assign static_win[DW-1-7*g -: 7] = SEG_BLANK;
    end
  end

  // NOTE: the message buffer is reset along with everything else, since a
  // mid-run reset must blank the message; this keeps it in flops, not a RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MSG_DEPTH; i++) begin
        msg[i] <= SEG_BLANK;
      end
    end else if (wr_ok) begin
      msg[wr_addr] <= wr_data;
    end
  end

  // NOTE: non-blocking updates mean a tick reading the entry written in the
  // same cycle sees the old contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode       <= MODE_SCROLL_L;
      len        <= DEPTH_L;
      rd_ptr     <= '0;
      phase      <= PHASE_SHOWN;
      digits     <= '1;
      led        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (cfg_we) begin
        mode   <= mode_t'(cfg_mode);
        len    <= len_clamped;
        rd_ptr <= cfg_start;
        phase  <= PHASE_SHOWN;
      end else if (tick) begin
        case (mode)
          MODE_SCROLL_L: begin
            digits     <= {digits[DW-8:0], rd_seg};
            led        <= {led[LED_W-2:0], rd_ptr == '0};
            frame_done <= (rd_ptr == last_idx);
            rd_ptr     <= (rd_ptr == last_idx) ? '0 : rd_ptr + 1'b1;
          end
          MODE_SCROLL_R: begin
            digits     <= {rd_seg, digits[DW-1:7]};
            led        <= {rd_ptr == last_idx, led[LED_W-1:1]};
            frame_done <= (rd_ptr == '0);
            rd_ptr     <= (rd_ptr == '0) ? last_idx : rd_ptr - 1'b1;
          end
          MODE_STATIC: begin
            digits     <= static_win;
            frame_done <= 1'b1;
          end
          default: begin
            phase <= ~phase;
            if (phase == PHASE_HIDDEN) begin
              digits     <= static_win;
              led        <= '1;
              frame_done <= 1'b1;
            end else begin
              digits <= '1;
              led    <= '0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scroll_displayer.sv
// Directed plus randomized checks of scroll_displayer against an array-based
// reference model of the display rules, compared after every clock edge.
module tb_scroll_displayer;
  import scroll_pkg::*;

  localparam int ND = 4;
  localparam int MD = 8;
  localparam int LW = 4;
  localparam int TD = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            wr_en;
  logic [2:0]      wr_addr;
  logic [6:0]      wr_data;
  logic            cfg_we;
  logic [1:0]      cfg_mode;
  logic [3:0]      cfg_len;
  logic [7*ND-1:0] digits;
  logic [LW-1:0]   led;
  logic            frame_done;

  always #5 clk = ~clk;

  scroll_displayer #(
    .NUM_DIGITS (ND),
    .MSG_DEPTH  (MD),
    .LED_W      (LW),
    .TICK_DIV   (TD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cfg_we     (cfg_we),
    .cfg_mode   (cfg_mode),
    .cfg_len    (cfg_len),
    .digits     (digits),
    .led        (led),
    .frame_done (frame_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: message array, digits as an array (index 0 = leftmost).
  logic [6:0]    m_msg [MD];
  logic [6:0]    m_dig [ND];
  logic [LW-1:0] m_led;
  logic          m_fd;
  int            m_mode, m_len, m_ptr, m_cnt;
  bit            m_shown;
  int            fd_seen;

  localparam logic [27:0] BUAA = {7'h00, 7'h41, 7'h08, 7'h08};
  localparam logic [27:0] UAAB = {7'h41, 7'h08, 7'h08, 7'h00};
  localparam logic [27:0] B1   = {7'h79, 7'h10, 7'h7F, 7'h7F};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7*ND-1:0] m_bus();
    logic [7*ND-1:0] b;
    for (int i = 0; i < ND; i++) b[7*(ND-1-i) +: 7] = m_dig[i];
    return b;
  endfunction

  task automatic m_window();
    for (int i = 0; i < ND; i++) m_dig[i] = (i < m_len) ? m_msg[i] : 7'h7F;
  endtask

  task automatic model_step();
    bit t;
    int l;
    if (rst) begin
      for (int i = 0; i < MD; i++) m_msg[i] = 7'h7F;
      for (int i = 0; i < ND; i++) m_dig[i] = 7'h7F;
      m_led = '0; m_fd = 1'b0; m_mode = 0; m_len = MD; m_ptr = 0; m_cnt = 0; m_shown = 1'b1;
      return;
    end
    t = en && (m_cnt == TD - 1);
    if (en) m_cnt = (m_cnt + 1) % TD;
    m_fd = 1'b0;
    if (cfg_we) begin
      l = int'(cfg_len);
      if (l == 0) l = 1;
      if (l > MD) l = MD;
      m_mode = int'(cfg_mode); m_len = l; m_shown = 1'b1;
      m_ptr = (m_mode == 1) ? l - 1 : 0;
    end else if (t) begin
      case (m_mode)
        0: begin
          for (int i = 0; i < ND - 1; i++) m_dig[i] = m_dig[i+1];
          m_dig[ND-1] = m_msg[m_ptr];
          m_led = {m_led[LW-2:0], m_ptr == 0};
          m_fd  = (m_ptr == m_len - 1);
          m_ptr = (m_ptr + 1) % m_len;
        end
        1: begin
          for (int i = ND - 1; i > 0; i--) m_dig[i] = m_dig[i-1];
          m_dig[0] = m_msg[m_ptr];
          m_led = {m_ptr == m_len - 1, m_led[LW-1:1]};
          m_fd  = (m_ptr == 0);
          m_ptr = (m_ptr + m_len - 1) % m_len;
        end
        2: begin
          m_window();
          m_fd = 1'b1;
        end
        default: begin
          m_shown = !m_shown;
          if (m_shown) begin
            m_window(); m_led = '1; m_fd = 1'b1;
          end else begin
            for (int i = 0; i < ND; i++) m_dig[i] = 7'h7F;
            m_led = '0;
          end
        end
      endcase
    end
    if (wr_en) m_msg[wr_addr] = wr_data;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("digits", 32'(digits), 32'(m_bus()));
    check("led", 32'(led), 32'(m_led));
    check("frame_done", 32'(frame_done), 32'(m_fd));
    if (frame_done === 1'b1) fd_seen++;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic wr(input logic [2:0] a, input logic [6:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] mode, input logic [3:0] len);
    cfg_we = 1'b1; cfg_mode = mode; cfg_len = len;
    cycle();
    cfg_we = 1'b0;
  endtask

  initial begin
    logic [7*ND-1:0] hold_d;
    logic [LW-1:0]   hold_l;

    rst = 1'b1; en = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    cfg_we = 1'b0; cfg_mode = '0; cfg_len = '0;
    run(2);
    rst = 1'b0;
    check("reset_digits", 32'(digits), 32'h0FFF_FFFF);
    check("reset_led", 32'(led), 32'h0);
    check("reset_fd", 32'(frame_done), 32'h0);
    run(TD - 1);
    check("idle_digits", 32'(digits), 32'h0FFF_FFFF);

    // Scroll left "BUAA"
    wr(3'd0, 7'h00); wr(3'd1, 7'h41); wr(3'd2, 7'h08); wr(3'd3, 7'h08);
    cfg(2'd0, 4'd4);
    en = 1'b1; fd_seen = 0;
    run(4 * TD - 1);
    check("sl_fd_early", 32'(fd_seen), 32'd0);
    run(1);
    check("sl_digits", 32'(digits), 32'(BUAA));
    check("sl_led", 32'(led), 32'b1000);
    check("sl_fd_4th", 32'(frame_done), 32'd1);
    run(TD);
    check("sl_5th", 32'(digits), 32'(UAAB));

    // Scroll right, same message
    en = 1'b0;
    cfg(2'd1, 4'd4);
    en = 1'b1; fd_seen = 0;
    run(4 * TD);
    check("sr_digits", 32'(digits), 32'(BUAA));
    check("sr_led", 32'(led), 32'b0001);
    check("sr_fd", 32'(fd_seen), 32'd1);
    check("sr_fd_4th", 32'(frame_done), 32'd1);

    // Length clamping
    en = 1'b0;
    cfg(2'd0, 4'd0);
    en = 1'b1; fd_seen = 0;
    run(4 * TD);
    check("len0_fd", 32'(fd_seen), 32'd4);
    check("len0_digits", 32'(digits), 32'h0);
    en = 1'b0;
    for (int i = 4; i < MD; i++) wr(3'(i), 7'($urandom));
    cfg(2'd0, 4'd12);
    en = 1'b1; fd_seen = 0;
    run(8 * TD - 1);
    check("len12_fd_early", 32'(fd_seen), 32'd0);
    run(1);
    check("len12_wrap", 32'(frame_done), 32'd1);

    // Freeze mid-scroll, resume from held counter
    run(TD + 2);
    en = 1'b0;
    hold_d = digits; hold_l = led;
    run(10);
    check("freeze_digits", 32'(digits), 32'(hold_d));
    check("freeze_led", 32'(led), 32'(hold_l));
    en = 1'b1;
    run(1);
    check("resume_tick", 32'(digits != hold_d), 32'd1);

    // Config coincident with a tick drops the tick
    run(TD - 1);
    hold_d = digits;
    cfg(2'd0, 4'd8);
    check("cfg_drop_digits", 32'(digits), 32'(hold_d));
    check("cfg_drop_fd", 32'(frame_done), 32'd0);
    run(TD);
    check("cfg_ptr0", 32'(digits[6:0]), 32'h00);

    // Blink "19"
    en = 1'b0;
    wr(3'd0, SEG_1); wr(3'd1, SEG_9);
    cfg(2'd3, 4'd2);
    en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      run(TD);
      check("blink_hidden", 32'(digits), 32'h0FFF_FFFF);
      check("blink_led0", 32'(led), 32'h0);
      run(TD);
      check("blink_shown", 32'(digits), 32'(B1));
      check("blink_ledF", 32'(led), 32'hF);
      check("blink_fd", 32'(frame_done), 32'd1);
    end

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      rst      = ($urandom_range(0, 249) == 0);
      en       = ($urandom_range(0, 9) != 0);
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_addr  = 3'($urandom);
      wr_data  = 7'($urandom);
      cfg_we   = ($urandom_range(0, 24) == 0);
      cfg_mode = 2'($urandom);
      cfg_len  = 4'($urandom);
      cycle();
    end
    wr_en = 1'b0; cfg_we = 1'b0;

    // Mid-scroll reset clears the message buffer too
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    check("rst2_digits", 32'(digits), 32'h0FFF_FFFF);
    check("rst2_led", 32'(led), 32'h0);
    en = 1'b0;
    cfg(2'd2, 4'd8);
    en = 1'b1;
    run(TD);
    check("rst2_msg_blank", 32'(digits), 32'h0FFF_FFFF);
    check("rst2_static_fd", 32'(frame_done), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/scroll_displayer.md
Name: scroll_displayer

Overview:
Parametrised multi-digit 7-segment message scroller with companion LED bar.
- Holds a writable message of segment codes; steps it across NUM_DIGITS displays on an internal tick.
- Four modes: scroll-left, scroll-right, static, blink.
- Replaces the fixed-text derived-clock scroller. Runs entirely on clk with a one-cycle tick enable, so no generated clocks.

Parameters:
NUM_DIGITS, 8, number of 7-segment digits driven
MSG_DEPTH, 16, message buffer entries (>=2)
LED_W, 8, LED bar width
TICK_DIV, 2_000_000, clk cycles per display step (>=1)
ADDR_W, $clog2(MSG_DEPTH), message address width (derived, localparam)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
en  in  1  run enable; low freezes tick counter, digits, led
wr_en  in  1  message write strobe
wr_addr  in  ADDR_W  message entry index
wr_data  in  7  segment code, active-low, {g,f,e,d,c,b,a}
cfg_we  in  1  configuration write strobe
cfg_mode  in  2  0 SCROLL_L, 1 SCROLL_R, 2 STATIC, 3 BLINK
cfg_len  in  ADDR_W+1  message length
digits  out  7*NUM_DIGITS  segment bus; digit 0 = MSBs (leftmost)
led  out  LED_W  LED bar
frame_done  out  1  one-cycle pulse on message wrap

Behaviour:
Interface:
- One clock, clk. Reset rst is synchronous and active-high. All state updates on posedge clk only.

Reset:
- digits all ones (blank), led 0, frame_done 0.
- mode SCROLL_L, len MSG_DEPTH, rd_ptr 0, tick counter 0, blink phase SHOWN.
- Every message entry = 7'h7F (blank).

Tick generation:
- Counter 0..TICK_DIV-1 advances only while en=1.
- tick=1 in the cycle the counter equals TICK_DIV-1 and en=1; the counter then returns to 0.
- First tick occurs TICK_DIV cycles after en rises from reset.
- en=0: counter holds, no tick.

Message write:
- wr_en writes wr_data to entry wr_addr next edge.
- wr_addr >= MSG_DEPTH is ignored.
- Writes are accepted regardless of en.
- Same-cycle read of the written entry by a tick returns the old data.

Config write:
- cfg_we latches mode and len.
- len is clamped: 0 becomes 1; > MSG_DEPTH becomes MSG_DEPTH.
- rd_ptr is set to 0 (SCROLL_L/STATIC/BLINK) or clamped_len-1 (SCROLL_R).
- Blink phase is set to SHOWN. digits and led are unchanged. The tick counter is not reset.
- cfg_we has priority: a tick in the same cycle is dropped (no digit/led/pointer update, no frame_done).

On tick, per mode:
- SCROLL_L: digits <= {digits[7*NUM_DIGITS-8:0], msg[rd_ptr]}. led <= {led[LED_W-2:0], rd_ptr==0}. rd_ptr wraps len-1 -> 0. frame_done=1 when the shifted-in index is len-1.
- SCROLL_R: digits <= {msg[rd_ptr], digits[7*NUM_DIGITS-1:7]}. led <= {rd_ptr==len-1, led[LED_W-1:1]}. rd_ptr decrements, wrapping 0 -> len-1. frame_done=1 when the shifted-in index is 0.
- STATIC: digit i = msg[i] for i < len, else blank. led holds. frame_done=1 on every tick.
- BLINK: phase toggles. When SHOWN, digits = static window and led all ones. When HIDDEN, digits blank and led 0. frame_done=1 on each transition to SHOWN.

Other rules:
- No tick: digits, led and rd_ptr hold. frame_done=0 except in the tick cycle.
- Outputs are registered, so changes appear the edge after the tick cycle.
- Reset asserted mid-scroll restores the full reset state on the next edge, including the message buffer.

Decomposition:
- Package scroll_pkg holds:
  - mode encodings MODE_SCROLL_L/R, MODE_STATIC, MODE_BLINK
  - segment constants SEG_BLANK=7'h7F, SEG_DASH=7'h3F, SEG_0..SEG_9, SEG_A/B/U
- One sub-module, tick_gen: parameter DIV. Ports clk, rst, en, tick.
- Message buffer, pointer and mode logic stay in scroll_displayer.

Test Plan:
Bench parameters: NUM_DIGITS=4, MSG_DEPTH=8, LED_W=4, TICK_DIV=3.

1. Reset -> digits=28'hFFFFFFF, led=0, frame_done=0. After TICK_DIV-1 idle cycles with en=0, no change.
2. Write B,U,A,A (00,41,08,08); cfg len=4, SCROLL_L; en=1. Ticks every 3 cycles. After 4 ticks: digits={00,41,08,08}, led=4'b1000, frame_done pulsed on 4th tick only. The 5th tick shifts in B.
3. Same message, SCROLL_R. After 4 ticks: digits={00,41,08,08}, frame_done on 4th tick, led=4'b0001.
4. cfg_len=0 -> effective len 1, frame_done every tick, all digits equal msg[0] after 4 ticks. cfg_len=12 -> clamps to 8 (wrap after 8 ticks).
5. en low for 10 cycles mid-scroll -> digits/led frozen, next tick exactly 1 cycle after en returns (counter resumes at its held value). cfg_we coincident with a tick -> no shift that cycle, rd_ptr=0.
6. BLINK, len=2, msg={SEG_1,SEG_9} -> digits alternate {79,10,7F,7F} and all-blank each tick; led alternates 4'hF/0; frame_done on each SHOWN.
